// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the branch predictor: counter states, FSM states, stats width.
package branch_predictor_pkg;

  localparam int unsigned BP_STAT_WIDTH = 32;

  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  typedef enum logic {
    BP_ST_INIT = 1'b0,
    BP_ST_RUN  = 1'b1
  } bp_state_e;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next value of a 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != BP_CTR_ST) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != BP_CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, swept invalid after reset.
// Optional statistics counters enabled by defining BP_STATS_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter logic [1:0]  CTR_INIT = BP_CTR_WT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     lookup_en_i,
  input  logic [ADDR_W-1:0]        lookup_pc_i,
  output logic                     pred_taken_o,
  output logic [ADDR_W-1:0]        pred_target_o,
  output logic                     ready_o,
  input  logic                     upd_en_i,
  input  logic [ADDR_W-1:0]        upd_pc_i,
  input  logic                     upd_taken_i,
  input  logic [ADDR_W-1:0]        upd_target_i,
  input  logic                     upd_mispred_i,
  output logic [BP_STAT_WIDTH-1:0] stat_lookup_o,
  output logic [BP_STAT_WIDTH-1:0] stat_hit_o,
  output logic [BP_STAT_WIDTH-1:0] stat_mispred_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  bp_state_e         state_q;
  logic [IDX_W-1:0]  sweep_idx_q;
  logic              ready_q;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  // Init sweep: one valid bit cleared per cycle, RUN after the last index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= BP_ST_INIT;
      sweep_idx_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        BP_ST_INIT: begin
          sweep_idx_q <= sweep_idx_q + IDX_W'(1);
          if (sweep_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= BP_ST_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q     <= BP_ST_INIT;
          sweep_idx_q <= '0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign lk_hit = ready_q & lookup_en_i & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign pred_taken_o  = lk_hit & ctr_q[lk_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;
  logic              upd_ok;
  logic              upd_hit;
  logic              upd_alloc;
  logic [1:0]        ctr_nxt;

  assign upd_idx   = upd_pc_i[IDX_W+1:2];
  assign upd_tag   = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_ok    = upd_en_i & ready_q & ~rst_i;
  assign upd_hit   = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_alloc = upd_ok & ~upd_hit & upd_taken_i;

  bp_sat_counter u_sat_counter (
    .ctr_i (ctr_q[upd_idx]),
    .inc_i (upd_taken_i),
    .ctr_o (ctr_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (state_q == BP_ST_INIT) begin
      valid_q[sweep_idx_q] <= 1'b0;
    end else if (upd_alloc) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the valid vector alone gates their use.
  always_ff @(posedge clk_i) begin
    if (upd_ok) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
        if (upd_taken_i) target_q[upd_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        ctr_q[upd_idx]    <= CTR_INIT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [BP_STAT_WIDTH-1:0] stat_lookup_q;
  logic [BP_STAT_WIDTH-1:0] stat_hit_q;
  logic [BP_STAT_WIDTH-1:0] stat_mispred_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_lookup_q  <= '0;
      stat_hit_q     <= '0;
      stat_mispred_q <= '0;
    end else if (ready_q) begin
      if (lookup_en_i)              stat_lookup_q  <= stat_lookup_q + BP_STAT_WIDTH'(1);
      if (lk_hit)                   stat_hit_q     <= stat_hit_q + BP_STAT_WIDTH'(1);
      if (upd_en_i & upd_mispred_i) stat_mispred_q <= stat_mispred_q + BP_STAT_WIDTH'(1);
    end
  end

  assign stat_lookup_o  = stat_lookup_q;
  assign stat_hit_o     = stat_hit_q;
  assign stat_mispred_o = stat_mispred_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};
`else
  assign stat_lookup_o  = '0;
  assign stat_hit_o     = '0;
  assign stat_mispred_o = '0;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_mispred_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: reset sweep timing, directed vector table, random vs model, stats.
module tb_branch_predictor;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned ENTRIES = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              lk_en;
  logic [31:0]       lk_pc;
  logic              p_taken;
  logic [31:0]       p_target;
  logic              ready;
  logic              u_en;
  logic [31:0]       u_pc;
  logic              u_taken;
  logic [31:0]       u_target;
  logic              u_mp;
  logic [31:0]       st_lk, st_hit, st_mp;

  always #5 clk = ~clk;

  branch_predictor #(
    .ADDR_W   (ADDR_W),
    .ENTRIES  (ENTRIES),
    .CTR_INIT (2'b10)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lookup_en_i    (lk_en),
    .lookup_pc_i    (lk_pc),
    .pred_taken_o   (p_taken),
    .pred_target_o  (p_target),
    .ready_o        (ready),
    .upd_en_i       (u_en),
    .upd_pc_i       (u_pc),
    .upd_taken_i    (u_taken),
    .upd_target_i   (u_target),
    .upd_mispred_i  (u_mp),
    .stat_lookup_o  (st_lk),
    .stat_hit_o     (st_hit),
    .stat_mispred_o (st_mp)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: table of entries addressed by word index modulo ENTRIES.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_ready;
  int          s_lk, s_hit, s_mp;

  function automatic int ent(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ent(pc)] && (m_tag[ent(pc)] == tagof(pc));
  endfunction

  task automatic m_predict(output bit t, output logic [31:0] tg);
    t = m_ready && lk_en && m_hit(lk_pc) && (m_ctr[ent(lk_pc)] >= 2);
    tg = t ? m_tgt[ent(lk_pc)] : lk_pc + 32'd4;
  endtask

  task automatic m_commit();
    int i;
    if (!m_ready) return;
    if (lk_en) s_lk++;
    if (lk_en && m_hit(lk_pc)) s_hit++;
    if (u_en && u_mp) s_mp++;
    if (!u_en) return;
    i = ent(u_pc);
    if (m_hit(u_pc)) begin
      if (u_taken) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = u_target;
      end else begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (u_taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tagof(u_pc);
      m_tgt[i]   = u_target;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit e, input logic [31:0] pc, input bit ue, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utg, input bit ump);
    lk_en = e; lk_pc = pc; u_en = ue; u_pc = upc; u_taken = ut; u_target = utg; u_mp = ump;
  endtask

  // Inputs already applied; check the combinational prediction, then clock.
  task automatic cycle_check(input string nm, input bit et, input logic [31:0] etg);
    #1;
    check({nm, ".taken"}, 32'(p_taken), 32'(et));
    check({nm, ".target"}, p_target, etg);
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    @(posedge clk);
    m_commit();
    #1;
  endtask

  // Assert reset for one edge, then count cycles until ready_o rises.
  task automatic reset_and_sweep(input string nm, input int abort_at);
    int cnt;
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    rst = 1'b1;
    m_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_lk = 0; s_hit = 0; s_mp = 0;
    check({nm, ".ready_rst"}, 32'(ready), 32'd0);
    check({nm, ".stat_lk_rst"}, st_lk, 32'd0);
    check({nm, ".stat_hit_rst"}, st_hit, 32'd0);
    check({nm, ".stat_mp_rst"}, st_mp, 32'd0);
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #1;
      check({nm, ".ready_mid"}, 32'(ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    drive(1, 32'h100, 0, 32'h0, 0, 32'h0, 0);
    #1;
    check({nm, ".sweep_taken"}, 32'(p_taken), 32'd0);
    check({nm, ".sweep_target"}, p_target, 32'h104);
    cnt = 0;
    while (!ready && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({nm, ".sweep_cycles"}, 32'(cnt), 32'd64);
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    m_ready = 1;
  endtask

  typedef struct {
    bit          e;
    logic [31:0] pc;
    bit          ue;
    logic [31:0] upc;
    bit          ut;
    logic [31:0] utg;
    bit          exp_t;
    logic [31:0] exp_tg;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit          et;
    logic [31:0] etg;

    vecs = '{
      '{1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104},  // allocate; lookup sees pre-update miss
      '{1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 32'h80},
      '{1, 32'h104, 0, 32'h0,   0, 32'h0,  0, 32'h108},
      '{1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h80},   // ctr 2 -> 1
      '{1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h104},
      '{1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104},  // ctr 1 -> 2
      '{1, 32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80},   // ctr 2 -> 3
      '{1, 32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h80},   // ctr 3 -> 2
      '{1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 32'h80},
      '{1, 32'h100, 1, 32'h100, 1, 32'h40, 1, 32'h80},   // collision: old target
      '{1, 32'h100, 0, 32'h0,   0, 32'h0,  1, 32'h40},
      '{1, 32'h100, 1, 32'h200, 1, 32'h300, 1, 32'h40},  // alias allocate evicts 0x100
      '{1, 32'h100, 0, 32'h0,   0, 32'h0,  0, 32'h104},
      '{1, 32'h200, 0, 32'h0,   0, 32'h0,  1, 32'h300},
      '{0, 32'h200, 0, 32'h0,   0, 32'h0,  0, 32'h204}
    };

    rst = 1'b0;
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    m_ready = 0;
    @(posedge clk);
    #1;

    reset_and_sweep("reset", 0);
    reset_and_sweep("restart", 20);

    foreach (vecs[k]) begin
      drive(vecs[k].e, vecs[k].pc, vecs[k].ue, vecs[k].upc, vecs[k].ut, vecs[k].utg, 0);
      cycle_check($sformatf("vec%0d", k), vecs[k].exp_t, vecs[k].exp_tg);
    end

    for (int n = 0; n < 600; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      b = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2);
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1, b,
            $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
      m_predict(et, etg);
      cycle_check($sformatf("rand%0d", n), et, etg);
    end
    idle_cycle();

`ifdef BP_STATS_EN
    check("rand.stat_lookup", st_lk, 32'(s_lk));
    check("rand.stat_hit", st_hit, 32'(s_hit));
    check("rand.stat_mispred", st_mp, 32'(s_mp));
`else
    check("rand.stat_lookup", st_lk, 32'd0);
    check("rand.stat_hit", st_hit, 32'd0);
    check("rand.stat_mispred", st_mp, 32'd0);
`endif

    // 10 lookups with 4 hits, 3 mispredicted updates.
    reset_and_sweep("stats", 0);
    drive(0, 32'h0, 1, 32'h100, 1, 32'h80, 1);
    cycle_check("st_alloc", 0, 32'h4);
    for (int n = 0; n < 10; n++) begin
      drive(1, (n < 4) ? 32'h100 : 32'h104, 0, 32'h0, 0, 32'h0, 0);
      cycle_check($sformatf("st_lk%0d", n), n < 4, (n < 4) ? 32'h80 : 32'h108);
    end
    for (int n = 0; n < 2; n++) begin
      drive(0, 32'h0, 1, 32'h900, 0, 32'h0, 1);
      cycle_check($sformatf("st_mp%0d", n), 0, 32'h4);
    end
    idle_cycle();

`ifdef BP_STATS_EN
    check("stats.lookup", st_lk, 32'd10);
    check("stats.hit", st_hit, 32'd4);
    check("stats.mispred", st_mp, 32'd3);
`else
    check("stats.lookup", st_lk, 32'd0);
    check("stats.hit", st_hit, 32'd0);
    check("stats.mispred", st_mp, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
